cdc_hs_tx: RTL and testbench

CDC_HS_TX -- requirements
Module: cdc_hs_tx

---
 rtl/cdc_hs_tx_if.sv | 23 ++
 rtl/cdc_hs_tx.sv | 136 +++++++++++++
 tb/tb_cdc_hs_tx.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/cdc_hs_tx_if.sv
// cdc_hs_tx_if: handshake bundle between a word source, the cdc_hs_tx
// sender and the far-domain receiver.
interface cdc_hs_tx_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] data_id;
  logic              valid_id;
  logic              ready_od;
  logic [DATA_W-1:0] data_od;
  logic              req_od;
  logic              ack_id;
  logic              timeout_od;

  modport master (
    output data_id, valid_id, ack_id,
    input  ready_od, data_od, req_od, timeout_od
  );

  modport slave (
    input  data_id, valid_id, ack_id,
    output ready_od, data_od, req_od, timeout_od
  );
endinterface

// File: rtl/cdc_hs_tx.sv
// cdc_hs_tx: four-phase req/ack sender pushing one word to a far clock domain.
// Optional handshake abort timer enabled by macro CDC_HS_TX_TIMEOUT_EN.
module cdc_hs_tx #(
  parameter int DATA_W           = 8,
  parameter int P_NO_SYNC_STAGES = 2,
  parameter int P_TIMEOUT        = 255
) (
  input logic          clk,
  input logic          rst_n,
  cdc_hs_tx_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ_HI = 2'd1,
    REQ_LO = 2'd2
  } state_e;

  if (P_NO_SYNC_STAGES < 2 || P_NO_SYNC_STAGES > 4 ||
      P_TIMEOUT < 1 || P_TIMEOUT > 65535) begin : g_bad_cfg
  end

  state_e                    state_q, state_d;
  logic                      req_q, req_d;
  logic [DATA_W-1:0]         data_q, data_d;
  logic [P_NO_SYNC_STAGES-1:0] sync_q, sync_d;
  logic                      ack_s;

`ifdef CDC_HS_TX_TIMEOUT_EN
  localparam logic [15:0] TMO_LIM = 16'(P_TIMEOUT);
  logic [15:0] cnt_q, cnt_d;
  logic        tmo_q, tmo_d;
`endif

  assign ack_s        = sync_q[P_NO_SYNC_STAGES-1];
  assign bus.ready_od = (state_q == IDLE);
  assign bus.req_od   = req_q;
  assign bus.data_od  = data_q;
`ifdef CDC_HS_TX_TIMEOUT_EN
  assign bus.timeout_od = tmo_q;
`else
  assign bus.timeout_od = 1'b0;
`endif

  // shift the far-domain ack into the local clock domain
  always_comb begin
    sync_d = {sync_q[P_NO_SYNC_STAGES-2:0], bus.ack_id};
  end

  // ack synchronizer chain
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  // handshake sequencing and optional abort timer
  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    data_d  = data_q;
`ifdef CDC_HS_TX_TIMEOUT_EN
    cnt_d   = cnt_q;
    tmo_d   = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        if (bus.valid_id) begin
          state_d = REQ_HI;
          req_d   = 1'b1;
          data_d  = bus.data_id;
`ifdef CDC_HS_TX_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      REQ_HI: begin
        if (ack_s) begin
          state_d = REQ_LO;
          req_d   = 1'b0;
`ifdef CDC_HS_TX_TIMEOUT_EN
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 16'd1;
          if (cnt_d == TMO_LIM) begin
            state_d = IDLE;
            req_d   = 1'b0;
            tmo_d   = 1'b1;
          end
`endif
        end
      end
      REQ_LO: begin
        if (!ack_s) begin
          state_d = IDLE;
`ifdef CDC_HS_TX_TIMEOUT_EN
        end else begin
          cnt_d = cnt_q + 16'd1;
          if (cnt_d == TMO_LIM) begin
            state_d = IDLE;
            tmo_d   = 1'b1;
          end
`endif
        end
      end
      default: begin
        state_d = IDLE;
        req_d   = 1'b0;
      end
    endcase
  end

  // FSM state and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      data_q  <= '0;
`ifdef CDC_HS_TX_TIMEOUT_EN
      cnt_q   <= '0;
      tmo_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      data_q  <= data_d;
`ifdef CDC_HS_TX_TIMEOUT_EN
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
`endif
    end
  end

endmodule

// File: tb/tb_cdc_hs_tx.sv
// tb_cdc_hs_tx: directed bench for cdc_hs_tx with a 2-stage ack sync.
// Build with +define+CDC_HS_TX_TIMEOUT_EN to exercise the abort timer.
module tb_cdc_hs_tx;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cdc_hs_tx_if #(.DATA_W(8)) bus ();

  cdc_hs_tx #(
    .DATA_W(8),
    .P_NO_SYNC_STAGES(2),
    .P_TIMEOUT(10)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus.slave)
  );

  int n_chk = 0;
  int n_err = 0;

  logic       ack_man = 1'b0;
  logic       ack_auto = 1'b0;
  logic [2:0] ack_pipe = 3'b000;

  // far-end model: ack follows req with 3-cycle latency
  always @(posedge clk) ack_pipe <= {ack_pipe[1:0], bus.req_od};
  assign bus.ack_id = ack_auto ? ack_pipe[2] : ack_man;

  logic       mon_en = 1'b0;
  logic       req_prev = 1'b0;
  logic [7:0] seen[$];

  // record the word presented on every req rising edge
  always @(negedge clk) begin
    if (mon_en && bus.req_od && !req_prev) seen.push_back(bus.data_od);
    req_prev <= bus.req_od;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad;
    int tmo_seen;
    bus.data_id  = 8'h00;
    bus.valid_id = 1'b0;

    // reset state
    tick();
    tick();
    chk("rst_ready", bus.ready_od, 1);
    chk("rst_req", bus.req_od, 0);
    chk("rst_data", bus.data_od, 0);
    chk("rst_tmo", bus.timeout_od, 0);
    rst_n = 1'b1;
    tick();
    chk("idle_ready", bus.ready_od, 1);

    // basic transfer of 0xA5, manual ack after 3 cycles
    bus.data_id  = 8'hA5;
    bus.valid_id = 1'b1;
    tick();
    bus.valid_id = 1'b0;
    chk("basic_data", bus.data_od, 8'hA5);
    chk("basic_req", bus.req_od, 1);
    chk("basic_busy", bus.ready_od, 0);
    tick();
    tick();
    ack_man = 1'b1;
    tick();
    chk("basic_req_e1", bus.req_od, 1);
    tick();
    chk("basic_req_e2", bus.req_od, 1);
    tick();
    chk("basic_req_fall", bus.req_od, 0);
    chk("basic_reqlo_busy", bus.ready_od, 0);
    ack_man = 1'b0;
    tick();
    tick();
    chk("basic_lo_wait", bus.ready_od, 0);
    tick();
    chk("basic_ready_back", bus.ready_od, 1);

    // back-to-back words with auto ack
    ack_auto = 1'b1;
    mon_en   = 1'b1;
    for (int w = 0; w < 3; w++) begin
      bus.data_id  = 8'(w + 1);
      bus.valid_id = 1'b1;
      for (int i = 0; i < 40 && !bus.ready_od; i++) tick();
      chk("b2b_ready", bus.ready_od, 1);
      tick();
    end
    bus.valid_id = 1'b0;
    for (int i = 0; i < 40 && !bus.ready_od; i++) tick();
    for (int i = 0; i < 10; i++) tick();
    chk("b2b_count", seen.size(), 3);
    if (seen.size() == 3) begin
      chk("b2b_w0", seen[0], 8'h01);
      chk("b2b_w1", seen[1], 8'h02);
      chk("b2b_w2", seen[2], 8'h03);
    end
    mon_en   = 1'b0;
    ack_auto = 1'b0;
    tick();

    // blocked source: data_id changes while busy
    bus.data_id  = 8'h3C;
    bus.valid_id = 1'b1;
    tick();
    chk("blk_load", bus.data_od, 8'h3C);
    bus.data_id = 8'hFF;
    tick();
    tick();
    tick();
    chk("blk_hold_hi", bus.data_od, 8'h3C);
    chk("blk_req_hi", bus.req_od, 1);
    ack_man = 1'b1;
    tick();
    tick();
    tick();
    chk("blk_req_lo", bus.req_od, 0);
    chk("blk_hold_lo", bus.data_od, 8'h3C);
    ack_man = 1'b0;
    tick();
    tick();
    tick();
    chk("blk_idle", bus.ready_od, 1);
    chk("blk_hold_idle", bus.data_od, 8'h3C);
    tick();
    chk("blk_next", bus.data_od, 8'hFF);
    bus.valid_id = 1'b0;
    ack_man = 1'b1;
    tick();
    tick();
    tick();
    ack_man = 1'b0;
    tick();
    tick();
    tick();
    chk("blk_done", bus.ready_od, 1);

    // reset in REQ_HI drops req immediately
    bus.data_id  = 8'h66;
    bus.valid_id = 1'b1;
    tick();
    bus.valid_id = 1'b0;
    chk("rhi_req", bus.req_od, 1);
    rst_n = 1'b0;
    #1;
    chk("rhi_req_drop", bus.req_od, 0);
    chk("rhi_data_clr", bus.data_od, 0);
    tick();
    rst_n = 1'b1;
    #1;
    chk("rhi_ready", bus.ready_od, 1);

    // reset in REQ_LO
    tick();
    bus.data_id  = 8'h77;
    bus.valid_id = 1'b1;
    tick();
    bus.valid_id = 1'b0;
    ack_man = 1'b1;
    tick();
    tick();
    tick();
    chk("rlo_in_lo", bus.ready_od, 0);
    chk("rlo_data", bus.data_od, 8'h77);
    rst_n = 1'b0;
    #1;
    chk("rlo_req", bus.req_od, 0);
    chk("rlo_data_clr", bus.data_od, 0);
    ack_man = 1'b0;
    tick();
    rst_n = 1'b1;
    #1;
    chk("rlo_ready_rel", bus.ready_od, 1);
    tick();
    chk("rlo_ready_e1", bus.ready_od, 1);

    // spurious ack in IDLE, then send 0x5A
    ack_man = 1'b1;
    tick();
    tick();
    tick();
    chk("spur_ready", bus.ready_od, 1);
    bus.data_id  = 8'h5A;
    bus.valid_id = 1'b1;
    tick();
    bus.valid_id = 1'b0;
    chk("spur_data", bus.data_od, 8'h5A);
    chk("spur_req", bus.req_od, 1);
    tick();
    chk("spur_req_fast", bus.req_od, 0);
    chk("spur_in_lo", bus.ready_od, 0);
    tick();
    tick();
    chk("spur_wait", bus.ready_od, 0);
    ack_man = 1'b0;
    tick();
    tick();
    chk("spur_wait2", bus.ready_od, 0);
    tick();
    chk("spur_idle", bus.ready_od, 1);

    // stuck-low ack
    bus.data_id  = 8'hC3;
    bus.valid_id = 1'b1;
    tick();
    bus.valid_id = 1'b0;
`ifdef CDC_HS_TX_TIMEOUT_EN
    bad = 0;
    for (int i = 1; i < 10; i++) begin
      tick();
      if (bus.req_od !== 1'b1 || bus.timeout_od !== 1'b0) bad++;
    end
    chk("tmo_pre", bad, 0);
    tick();
    chk("tmo_req", bus.req_od, 0);
    chk("tmo_pulse", bus.timeout_od, 1);
    chk("tmo_ready", bus.ready_od, 1);
    tick();
    chk("tmo_pulse_end", bus.timeout_od, 0);
`else
    bad = 0;
    tmo_seen = 0;
    for (int i = 0; i < 1000; i++) begin
      tick();
      if (bus.req_od !== 1'b1) bad++;
      if (bus.timeout_od !== 1'b0) tmo_seen++;
    end
    chk("notmo_req", bad, 0);
    chk("notmo_pulse", tmo_seen, 0);
    ack_man = 1'b1;
    tick();
    tick();
    tick();
    ack_man = 1'b0;
    tick();
    tick();
    tick();
    chk("notmo_done", bus.ready_od, 1);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
